pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush controller for the 5-stage pipeline. Generates per-stage write enables and bubble
//  strobes for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. Resolves load-use hazards, taken
//  branches/jumps and multi-cycle data-memory accesses. Keeps stall/flush performance counters.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles in MEM_WAIT before entering HALT (>=2)
//  CNT_W        16  width of performance counters
// PORTS
//  Clk             in   1      rising-edge clock
//  Reset           in   1      synchronous, active-high reset
//  IDEX_MemRead    in   1      instruction in EX is a load
//  IDEX_WriteReg   in   5      destination register of instruction in EX
//  IFID_Rs         in   5      rs of instruction in ID
//  IFID_Rt         in   5      rt of instruction in ID
//  BranchTaken     in   1      branch/jump resolved taken in ID this cycle
//  MemReq          in   1      EX/MEM holds a load/store this cycle
//  MemReady        in   1      data memory completes the access this cycle
//  PCWrite         out  1      PC load enable
//  IFIDWrite       out  1      IF/ID load enable
//  IFIDFlush       out  1      IF/ID loads a NOP
//  IDEXWrite       out  1      ID/EX load enable
//  IDEXBubble      out  1      ID/EX loads zeroed controls (RegWrite/MemRead/MemWrite=0)
//  EXMEMWrite      out  1      EX/MEM load enable
//  MEMWBBubble     out  1      MEM/WB loads RegWriteIn=0 (MEM/WB itself always clocks)
//  Halted          out  1      sticky: memory timeout occurred
//  StallCycles     out  CNT_W  saturating count of cycles with PCWrite=0 (excl. Reset/HALT)
//  FlushCount      out  CNT_W  saturating count of IFIDFlush pulses (excl. Reset)
// BEHAVIOUR
//  - States: RUN(0), MEM_WAIT(1), HALT(2). Reset -> RUN; WaitCnt, counters, Halted cleared to 0.
//  - Outputs combinational from state+inputs. While Reset=1: PCWrite=IFIDWrite=IDEXWrite=EXMEMWrite=0,
//    IFIDFlush=IDEXBubble=MEMWBBubble=1 (pipeline fills with bubbles); counters do not count.
//  - LoadUse = IDEX_MemRead & (IDEX_WriteReg!=0) & (IDEX_WriteReg==IFID_Rs | IDEX_WriteReg==IFID_Rt).
//  - MemStall = MemReq & ~MemReady.
//  - RUN, priority high->low:
//    1) MemStall: all write enables 0, MEMWBBubble=1, IFIDFlush=IDEXBubble=0; next MEM_WAIT, WaitCnt<=1.
//    2) LoadUse: PCWrite=IFIDWrite=0, IDEXBubble=1, IDEXWrite/EXMEMWrite=1; BranchTaken ignored
//       (branch re-evaluates next cycle). Stays RUN; one bubble per hazard.
//    3) BranchTaken: all enables 1, IFIDFlush=1 (single cycle, zero delay slot).
//    4) else all enables 1, no bubbles.
//  - MEM_WAIT: if MemReady: behave as RUN rows 2-4 this cycle (access completes, MEM/WB captures
//    result), next RUN, WaitCnt<=0. Else freeze as row 1, WaitCnt<=WaitCnt+1; if WaitCnt==MEM_TIMEOUT-1
//    next HALT, Halted<=1. MemReq not re-sampled; controller assumes EX/MEM holds it.
//  - HALT: freeze as row 1 indefinitely; only Reset exits. Counters frozen.
//  - StallCycles/FlushCount increment by 1 per qualifying cycle, saturate at 2^CNT_W-1, no wrap.
//  - Reset mid-MEM_WAIT or HALT: next cycle RUN, all state cleared; pending access discarded.
// TESTING
//  - Reset held 3 cyc -> enables 0, bubbles 1; release with no hazards -> all enables 1, counters 0.
//  - IDEX_MemRead=1, IDEX_WriteReg=8, IFID_Rt=8, BranchTaken=1 -> PCWrite=0, IDEXBubble=1, IFIDFlush=0,
//    StallCycles=1; same with IDEX_WriteReg=0 -> no stall.
//  - MemReq=1, MemReady low 3 cyc then high -> 3 frozen cyc, MEMWBBubble=1 each, release on 4th, StallCycles=3.
//  - MemReq=1, MemReady never -> HALT after MEM_TIMEOUT=16 cyc, Halted=1; Reset -> RUN, Halted=0.
//  - BranchTaken=1 for 2 consecutive RUN cycles -> IFIDFlush=1 both, FlushCount=2; with CNT_W=2 and
//    5 flushes -> FlushCount=3 (saturated).
//  - MemStall and LoadUse same cycle -> freeze wins; on MemReady cycle LoadUse bubble applied.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, taken-branch flushes,
// multi-cycle data-memory freezes with a timeout into HALT, plus saturating stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             IDEX_MemRead,
  input  logic [4:0]       IDEX_WriteReg,
  input  logic [4:0]       IFID_Rs,
  input  logic [4:0]       IFID_Rt,
  input  logic             BranchTaken,
  input  logic             MemReq,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic             IDEXWrite,
  output logic             IDEXBubble,
  output logic             EXMEMWrite,
  output logic             MEMWBBubble,
  output logic             Halted,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCount
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [WC_W-1:0] wait_cnt;
  logic [WC_W-1:0] wait_nxt;
  logic            halt_set;
  logic            load_use;
  logic            mem_stall;
  logic            freeze;
  logic            active;
  logic            stall_cnt_en;
  logic            flush_cnt_en;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign load_use  = IDEX_MemRead && (IDEX_WriteReg != 5'd0) &&
                     ((IDEX_WriteReg == IFID_Rs) || (IDEX_WriteReg == IFID_Rt));
  assign mem_stall = MemReq && !MemReady;
  assign active    = (state == RUN) || (state == MEM_WAIT);

  // Any encoding outside RUN/MEM_WAIT is treated like HALT: hold the whole pipeline.
  assign freeze = ((state == RUN) && mem_stall) ||
                  ((state == MEM_WAIT) && !MemReady) ||
                  !active;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= RUN;
      wait_cnt <= '0;
      Halted   <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      Halted   <= Halted | halt_set;
    end
  end

  // MemReq is not re-sampled in MEM_WAIT; the access is assumed to sit in EX/MEM until MemReady.
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    halt_set  = 1'b0;
    case (state)
      RUN: begin
        if (mem_stall) begin
          state_nxt = MEM_WAIT;
          wait_nxt  = WC_W'(1);
        end
      end
      MEM_WAIT: begin
        if (MemReady) begin
          state_nxt = RUN;
          wait_nxt  = '0;
        end else begin
          wait_nxt = wait_cnt + WC_W'(1);
          if (wait_cnt == WC_W'(MEM_TIMEOUT - 1)) begin
            state_nxt = HALT;
            halt_set  = 1'b1;
          end
        end
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = HALT;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b1;
    IFIDWrite   = 1'b1;
    IFIDFlush   = 1'b0;
    IDEXWrite   = 1'b1;
    IDEXBubble  = 1'b0;
    EXMEMWrite  = 1'b1;
    MEMWBBubble = 1'b0;
    if (Reset) begin
      PCWrite     = 1'b0;
      IFIDWrite   = 1'b0;
      IFIDFlush   = 1'b1;
      IDEXWrite   = 1'b0;
      IDEXBubble  = 1'b1;
      EXMEMWrite  = 1'b0;
      MEMWBBubble = 1'b1;
    end else if (freeze) begin
      PCWrite     = 1'b0;
      IFIDWrite   = 1'b0;
      IDEXWrite   = 1'b0;
      EXMEMWrite  = 1'b0;
      MEMWBBubble = 1'b1;
    end else if (load_use) begin
      // The branch in ID, if any, is re-resolved next cycle once the load data is forwardable.
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXBubble = 1'b1;
    end else if (BranchTaken) begin
      IFIDFlush = 1'b1;
    end
  end

  assign stall_cnt_en = !Reset && !PCWrite && active;
  assign flush_cnt_en = !Reset && IFIDFlush;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      StallCycles <= '0;
      FlushCount  <= '0;
    end else begin
      if (stall_cnt_en) StallCycles <= sat_inc(StallCycles);
      if (flush_cnt_en) FlushCount  <= sat_inc(FlushCount);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench with a scoreboard queue; a 2-bit-counter instance checks saturation.
module tb_pipeline_hazard_ctrl;

  localparam logic [6:0] RST  = 7'b0010101;
  localparam logic [6:0] NORM = 7'b1101010;
  localparam logic [6:0] LU   = 7'b0001110;
  localparam logic [6:0] BR   = 7'b1111010;
  localparam logic [6:0] FRZ  = 7'b0000001;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        IDEX_MemRead = 1'b0;
  logic [4:0]  IDEX_WriteReg = 5'd0;
  logic [4:0]  IFID_Rs = 5'd0;
  logic [4:0]  IFID_Rt = 5'd0;
  logic        BranchTaken = 1'b0;
  logic        MemReq = 1'b0;
  logic        MemReady = 1'b0;

  logic        PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXBubble, EXMEMWrite, MEMWBBubble, Halted;
  logic [15:0] StallCycles, FlushCount;
  logic        PCWrite2, IFIDWrite2, IFIDFlush2, IDEXWrite2, IDEXBubble2, EXMEMWrite2, MEMWBBubble2, Halted2;
  logic [1:0]  StallCycles2, FlushCount2;

  typedef struct {
    string      name;
    logic [6:0] en;
    int         h;
    int         s;
    int         f;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .IDEX_MemRead(IDEX_MemRead), .IDEX_WriteReg(IDEX_WriteReg),
    .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .BranchTaken(BranchTaken), .MemReq(MemReq),
    .MemReady(MemReady), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush),
    .IDEXWrite(IDEXWrite), .IDEXBubble(IDEXBubble), .EXMEMWrite(EXMEMWrite),
    .MEMWBBubble(MEMWBBubble), .Halted(Halted), .StallCycles(StallCycles), .FlushCount(FlushCount)
  );

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(2)) dut2 (
    .Clk(Clk), .Reset(Reset), .IDEX_MemRead(IDEX_MemRead), .IDEX_WriteReg(IDEX_WriteReg),
    .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .BranchTaken(BranchTaken), .MemReq(MemReq),
    .MemReady(MemReady), .PCWrite(PCWrite2), .IFIDWrite(IFIDWrite2), .IFIDFlush(IFIDFlush2),
    .IDEXWrite(IDEXWrite2), .IDEXBubble(IDEXBubble2), .EXMEMWrite(EXMEMWrite2),
    .MEMWBBubble(MEMWBBubble2), .Halted(Halted2), .StallCycles(StallCycles2), .FlushCount(FlushCount2)
  );

  always #5 Clk = ~Clk;

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input string nm, input logic rst, input logic mr, input logic [4:0] wr,
                      input logic [4:0] rs, input logic [4:0] rt, input logic bt,
                      input logic mq, input logic mrdy,
                      input logic [6:0] en, input int h, input int s, input int f);
    exp_t e;
    @(posedge Clk);
    #1;
    Reset = rst; IDEX_MemRead = mr; IDEX_WriteReg = wr; IFID_Rs = rs; IFID_Rt = rt;
    BranchTaken = bt; MemReq = mq; MemReady = mrdy;
    e.name = nm; e.en = en; e.h = h; e.s = s; e.f = f;
    q.push_back(e);
  endtask

  // Monitor: outputs are combinational, so every cycle with a queued expectation is compared.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check({e.name, ".en"},
              {50'd0, PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXBubble, EXMEMWrite, MEMWBBubble,
               PCWrite2, IFIDWrite2, IFIDFlush2, IDEXWrite2, IDEXBubble2, EXMEMWrite2, MEMWBBubble2},
              {50'd0, e.en, e.en});
        if (e.h >= 0)
          check({e.name, ".halted"}, {62'd0, Halted, Halted2}, {62'd0, e.h[0], e.h[0]});
        if (e.s >= 0) begin
          check({e.name, ".stall"}, 64'(StallCycles), 64'(e.s));
          check({e.name, ".stall2"}, 64'(StallCycles2), 64'(sat3(e.s)));
        end
        if (e.f >= 0) begin
          check({e.name, ".flush"}, 64'(FlushCount), 64'(e.f));
          check({e.name, ".flush2"}, 64'(FlushCount2), 64'(sat3(e.f)));
        end
      end
    end
  end

  initial begin
    //    name        rst mr wr    rs    rt    bt mq rdy  en    h   s   f
    step("rst1",      1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0,  RST, -1, -1, -1);
    step("rst2",      1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0,  RST,  0,  0,  0);
    step("rst3",      1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0,  RST,  0,  0,  0);
    step("idle1",     0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0,  NORM, 0,  0,  0);
    step("idle2",     0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0,  NORM, 0,  0,  0);
    step("lu_rt_br",  0, 1, 5'd8, 5'd0, 5'd8, 1, 0, 0,  LU,   0,  0,  0);
    step("br_reeval", 0, 0, 5'd0, 5'd0, 5'd8, 1, 0, 0,  BR,   0,  1,  0);
    step("lu_r0",     0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0,  NORM, 0,  1,  1);
    step("lu_rs",     0, 1, 5'd5, 5'd5, 5'd9, 0, 0, 0,  LU,   0,  1,  1);
    step("nolu",      0, 0, 5'd5, 5'd5, 5'd9, 0, 0, 0,  NORM, 0,  2,  1);
    step("br1",       0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0,  BR,   0,  2,  1);
    step("br2",       0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0,  BR,   0,  2,  2);
    step("after_br",  0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0,  NORM, 0,  2,  3);
    step("mw_a",      0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0,  FRZ,  0,  2,  3);
    step("mw_b",      0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0,  FRZ,  0,  3,  3);
    step("mw_c",      0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0,  FRZ,  0,  4,  3);
    step("mw_rdy",    0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1,  NORM, 0,  5,  3);
    step("mem_fast",  0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1,  NORM, 0,  5,  3);
    step("mw_lu",     0, 1, 5'd3, 5'd0, 5'd3, 1, 1, 0,  FRZ,  0,  5,  3);
    step("mw_lu_rdy", 0, 1, 5'd3, 5'd0, 5'd3, 1, 1, 1,  LU,   0,  6,  3);
    step("br3",       0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0,  BR,   0,  7,  3);
    step("br4",       0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0,  BR,   0,  7,  4);
    step("fc_sat",    0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0,  NORM, 0,  7,  5);
    step("to_enter",  0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0,  FRZ,  0,  7,  5);
    for (int i = 0; i < 15; i++)
      step("to_wait", 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0,  FRZ,  0,  8 + i, 5);
    step("halt1",     0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0,  FRZ,  1, 23,  5);
    step("halt_rdy",  0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1,  FRZ,  1, 23,  5);
    step("halt_br",   0, 1, 5'd4, 5'd4, 5'd0, 1, 0, 0,  FRZ,  1, 23,  5);
    step("halt_rst",  1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0,  RST,  1, 23,  5);
    step("post_rst",  0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0,  NORM, 0,  0,  0);
    step("mw_again",  0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0,  FRZ,  0,  0,  0);
    step("mw_rst",    1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0,  RST,  0,  1,  0);
    step("mw_disc",   0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0,  NORM, 0,  0,  0);
    step("stray_rdy", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1,  NORM, 0,  0,  0);
    repeat (3) @(negedge Clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
